// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the register file / busy scoreboard slice:
//   default geometry, address/data typedefs and the hard-wired zero
//   register index.
package reg_file_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_WIDTH      = 32;

  // x0 always reads zero, ignores writes and can never be reserved.
  localparam int REG_ZERO = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]      reg_data_t;

endpackage

// File: rtl/register_file_scoreboard_if.sv
// register_file_scoreboard_if
//   Bundles the read, write-back, reservation and flush signals of the
//   register file.
//   master : issue/writeback side (drives addresses, data, strobes)
//   slave  : register file (drives rdata, rs_busy, any_busy)
//   rs / rdata pack port i at [i*ADDR_WIDTH +: ADDR_WIDTH] / [i*WIDTH +: WIDTH].
interface register_file_scoreboard_if
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int READ_PORTS = 2
);

  logic [READ_PORTS*ADDR_WIDTH-1:0] rs;
  logic [READ_PORTS*WIDTH-1:0]      rdata;
  logic [READ_PORTS-1:0]            rs_busy;
  logic [ADDR_WIDTH-1:0]            wa_rd;
  logic [WIDTH-1:0]                 wa_wd;
  logic                             wa_we;
  logic [ADDR_WIDTH-1:0]            wl_rd;
  logic [WIDTH-1:0]                 wl_wd;
  logic                             wl_we;
  logic [ADDR_WIDTH-1:0]            resv_rd;
  logic                             resv_en;
  logic                             flush;
  logic                             any_busy;

  modport master (
    output rs, wa_rd, wa_wd, wa_we, wl_rd, wl_wd, wl_we, resv_rd, resv_en, flush,
    input  rdata, rs_busy, any_busy
  );

  modport slave (
    input  rs, wa_rd, wa_wd, wa_we, wl_rd, wl_wd, wl_we, resv_rd, resv_en, flush,
    output rdata, rs_busy, any_busy
  );

endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard
//   One busy bit per architectural register.
//   Priority per register on each clock edge: flush clears everything,
//   otherwise a reservation sets the bit (a new producer is in flight, so
//   it beats a same-cycle release), otherwise a write on either port
//   releases it, otherwise it holds. Bit 0 is never set.
//   Ports: clk, rst (async, active high), wa_we/wa_rd, wl_we/wl_rd,
//          resv_en/resv_rd, flush -> busy vector, any_busy.
module register_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wa_we,
  input  logic [ADDR_WIDTH-1:0]        wa_rd,
  input  logic                         wl_we,
  input  logic [ADDR_WIDTH-1:0]        wl_rd,
  input  logic                         resv_en,
  input  logic [ADDR_WIDTH-1:0]        resv_rd,
  input  logic                         flush,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy,
  output logic                         any_busy
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (r != REG_ZERO) begin
        if (resv_en && (resv_rd == ADDR_WIDTH'(r))) begin
          busy_d[r] = 1'b1;
        end else if ((wa_we && (wa_rd == ADDR_WIDTH'(r))) ||
                     (wl_we && (wl_rd == ADDR_WIDTH'(r)))) begin
          busy_d[r] = 1'b0;
        end
      end
    end
    busy_d[REG_ZERO] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Multi-read, dual-write integer register file with optional same-cycle
//   write-to-read forwarding and a per-register busy scoreboard.
//   Ports: clk, rst (async, active high), bus (slave modport):
//     rs/rdata/rs_busy  - READ_PORTS combinational read ports
//     wa_*              - ALU write-back port
//     wl_*              - load write-back port (wins on address collision)
//     resv_*, flush     - scoreboard reservation / pipeline flush
//     any_busy          - OR of all registered busy bits
module register_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  register_file_scoreboard_if.slave bus
);

  localparam int                    NREGS     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
  localparam bit                    BYPASS_ON = (BYPASS != 0);

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [NREGS-1:0]            busy;

  // Register storage: flops rather than RAM because every entry must
  // clear asynchronously on reset.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (bus.wl_we && (bus.wl_rd == IDX)) begin
        reg_d = bus.wl_wd;
      end else if (bus.wa_we && (bus.wa_rd == IDX)) begin
        reg_d = bus.wa_wd;
      end
      if (IDX == ZERO_ADDR) begin
        reg_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_q[gi] = reg_q;
  end

  register_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wa_we    (bus.wa_we),
    .wa_rd    (bus.wa_rd),
    .wl_we    (bus.wl_we),
    .wl_rd    (bus.wl_rd),
    .resv_en  (bus.resv_en),
    .resv_rd  (bus.resv_rd),
    .flush    (bus.flush),
    .busy     (busy),
    .any_busy (bus.any_busy)
  );

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  nonzero;
    logic                  wl_hit;
    logic                  wa_hit;
    logic [WIDTH-1:0]      data;

    assign addr    = bus.rs[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign nonzero = (addr != ZERO_ADDR);
    // Hits only exist when forwarding is enabled.
    assign wl_hit  = BYPASS_ON && bus.wl_we && (bus.wl_rd == addr) && nonzero;
    assign wa_hit  = BYPASS_ON && bus.wa_we && (bus.wa_rd == addr) && nonzero;

    always_comb begin
      data = regs_q[addr];
      if (wl_hit) begin
        data = bus.wl_wd;
      end else if (wa_hit) begin
        data = bus.wa_wd;
      end
      // Forwarding must not leak write data while the file is held in reset.
      if (rst || !nonzero) begin
        data = '0;
      end
    end

    assign bus.rdata[gi*WIDTH +: WIDTH] = data;
    // A forwarded operand is available now, so it is not a hazard.
    assign bus.rs_busy[gi] = busy[addr] && !(wl_hit || wa_hit) && nonzero && !rst;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Testbench: drives a BYPASS=1 and a BYPASS=0 instance with identical
// stimulus and compares both against an array-based reference model.
module tb_register_file_scoreboard;
  import reg_file_pkg::*;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int RP = 2;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_scoreboard_if #(.ADDR_WIDTH(AW), .WIDTH(W), .READ_PORTS(RP)) if_b ();
  register_file_scoreboard_if #(.ADDR_WIDTH(AW), .WIDTH(W), .READ_PORTS(RP)) if_n ();

  register_file_scoreboard #(.ADDR_WIDTH(AW), .WIDTH(W), .READ_PORTS(RP), .BYPASS(1)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  register_file_scoreboard #(.ADDR_WIDTH(AW), .WIDTH(W), .READ_PORTS(RP), .BYPASS(0)) dut_n (
    .clk (clk), .rst (rst), .bus (if_n.slave)
  );

  assign if_n.rs      = if_b.rs;
  assign if_n.wa_rd   = if_b.wa_rd;
  assign if_n.wa_wd   = if_b.wa_wd;
  assign if_n.wa_we   = if_b.wa_we;
  assign if_n.wl_rd   = if_b.wl_rd;
  assign if_n.wl_wd   = if_b.wl_wd;
  assign if_n.wl_we   = if_b.wl_we;
  assign if_n.resv_rd = if_b.resv_rd;
  assign if_n.resv_en = if_b.resv_en;
  assign if_n.flush   = if_b.flush;

  // Reference model: architectural contents and busy set.
  reg_data_t        m_regs [NR];
  logic [NR-1:0]    m_busy;
  int               checks = 0;
  int               errors = 0;

  function automatic reg_data_t exp_rdata(reg_addr_t a, bit byp);
    if (rst || a == 0) return '0;
    if (byp && if_b.wl_we && if_b.wl_rd == a) return if_b.wl_wd;
    if (byp && if_b.wa_we && if_b.wa_rd == a) return if_b.wa_wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(reg_addr_t a, bit byp);
    bit fwd;
    fwd = (if_b.wl_we && if_b.wl_rd == a) || (if_b.wa_we && if_b.wa_rd == a);
    if (rst || a == 0) return 1'b0;
    return m_busy[a] && !(byp && fwd);
  endfunction

  task automatic chk_data(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int p = 0; p < RP; p++) begin
      reg_addr_t a;
      a = if_b.rs[p*AW +: AW];
      chk_data($sformatf("%s rdata_byp[%0d]", tag, p), if_b.rdata[p*W +: W], exp_rdata(a, 1'b1));
      chk_data($sformatf("%s rdata_nob[%0d]", tag, p), if_n.rdata[p*W +: W], exp_rdata(a, 1'b0));
      chk_bit($sformatf("%s rs_busy_byp[%0d]", tag, p), if_b.rs_busy[p], exp_busy(a, 1'b1));
      chk_bit($sformatf("%s rs_busy_nob[%0d]", tag, p), if_n.rs_busy[p], exp_busy(a, 1'b0));
    end
    chk_bit($sformatf("%s any_busy_byp", tag), if_b.any_busy, |m_busy);
    chk_bit($sformatf("%s any_busy_nob", tag), if_n.any_busy, |m_busy);
    $display("%0t %s rs=%h rdata_byp=%h rdata_nob=%h busy=%b/%b any=%b/%b", $time, tag,
             if_b.rs, if_b.rdata, if_n.rdata, if_b.rs_busy, if_n.rs_busy,
             if_b.any_busy, if_n.any_busy);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // Applied in order so that later rules override earlier ones:
  // ALU write, load write (load wins), reservation, flush.
  task automatic model_edge();
    if (rst) return;
    if (if_b.wa_we && if_b.wa_rd != 0) begin
      m_regs[if_b.wa_rd] = if_b.wa_wd;
      m_busy[if_b.wa_rd] = 1'b0;
    end
    if (if_b.wl_we && if_b.wl_rd != 0) begin
      m_regs[if_b.wl_rd] = if_b.wl_wd;
      m_busy[if_b.wl_rd] = 1'b0;
    end
    if (if_b.resv_en && if_b.resv_rd != 0) m_busy[if_b.resv_rd] = 1'b1;
    if (if_b.flush) m_busy = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    if_b.wa_we = 1'b0; if_b.wa_rd = '0; if_b.wa_wd = '0;
    if_b.wl_we = 1'b0; if_b.wl_rd = '0; if_b.wl_wd = '0;
    if_b.resv_en = 1'b0; if_b.resv_rd = '0;
    if_b.flush = 1'b0;
  endtask

  task automatic set_rs(reg_addr_t a0, reg_addr_t a1);
    if_b.rs = {a1, a0};
  endtask

  task automatic wr_a(reg_addr_t a, reg_data_t d);
    if_b.wa_we = 1'b1; if_b.wa_rd = a; if_b.wa_wd = d;
  endtask

  task automatic wr_l(reg_addr_t a, reg_data_t d);
    if_b.wl_we = 1'b1; if_b.wl_rd = a; if_b.wl_wd = d;
  endtask

  task automatic resv(reg_addr_t a);
    if_b.resv_en = 1'b1; if_b.resv_rd = a;
  endtask

  initial begin
    // Reset with reads of x1/x2, then a pending write to x5 across release.
    rst = 1'b1;
    model_reset();
    idle();
    set_rs(5'd1, 5'd2);
    #3 check_all("reset");
    wr_a(5'd5, 32'hDEADBEEF);
    set_rs(5'd5, 5'd2);
    #1 check_all("reset_wr_pending");
    #4 rst = 1'b0;
    #1 check_all("release_fwd");
    tick();
    idle();
    #1 check_all("x5_stored");

    // Register zero.
    wr_a(5'd0, 32'h1234);
    resv(5'd0);
    set_rs(5'd0, 5'd0);
    #1 check_all("x0_wr_resv");
    tick();
    idle();
    #1 check_all("x0_after");

    // Same-cycle collision on x3: load wins.
    wr_a(5'd3, 32'h11);
    wr_l(5'd3, 32'h22);
    set_rs(5'd3, 5'd3);
    #1 check_all("collide_x3");
    tick();
    idle();
    #1 check_all("x3_stored");

    // Scoreboard lifecycle on x7.
    resv(5'd7);
    set_rs(5'd7, 5'd0);
    #1 check_all("resv_x7");
    tick();
    idle();
    #1 check_all("x7_busy");
    wr_l(5'd7, 32'h99);
    #1 check_all("x7_release_fwd");
    tick();
    idle();
    #1 check_all("x7_released");

    // Reserve and write x4 in the same cycle: stays busy.
    resv(5'd4);
    wr_a(5'd4, 32'h44);
    set_rs(5'd4, 5'd7);
    #1 check_all("resv_wr_x4");
    tick();
    idle();
    #1 check_all("x4_still_busy");

    // Flush beats a same-cycle reservation.
    if_b.flush = 1'b1;
    resv(5'd6);
    set_rs(5'd6, 5'd4);
    #1 check_all("flush_resv_x6");
    tick();
    idle();
    #1 check_all("after_flush");

    // Build state on x1/x2, then pulse reset between clock edges.
    wr_a(5'd1, 32'hAA);
    resv(5'd1);
    tick();
    idle();
    resv(5'd2);
    tick();
    idle();
    set_rs(5'd1, 5'd2);
    #1 check_all("x1_x2_busy");
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    #1 rst = 1'b0;
    #1 check_all("post_reset");
    tick();

    // Randomized traffic, biased to a few registers for collisions.
    for (int it = 0; it < 300; it++) begin
      idle();
      if ($urandom_range(0, 2) != 0) wr_a(AW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) wr_l(AW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 0) resv(AW'($urandom_range(0, 7)));
      if_b.flush = ($urandom_range(0, 15) == 0);
      set_rs(AW'($urandom_range(0, 8)), AW'($urandom_range(0, NR - 1)));
      #1 check_all($sformatf("rand%0d", it));
      tick();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised successor to the single-write integer register file of the RV32 core.
- Adds configurable read-port count, two write ports (ALU writeback, load writeback), optional write-to-read bypass, asynchronous reset of all registers, and a per-register busy scoreboard for hazard detection in the pipelined core.
- Sits between decode/issue (reads, reservations) and the writeback stages (writes, busy release).

Parameters:
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
- WIDTH, 32, register data width.
- READ_PORTS, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rs  in  READ_PORTS*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  READ_PORTS*WIDTH  read data per port, same packing.
- rs_busy  out  READ_PORTS  busy flag of each read port's register.
- wa_rd  in  ADDR_WIDTH  ALU write address.
- wa_wd  in  WIDTH  ALU write data.
- wa_we  in  1  ALU write enable.
- wl_rd  in  ADDR_WIDTH  load write address.
- wl_wd  in  WIDTH  load write data.
- wl_we  in  1  load write enable.
- resv_rd  in  ADDR_WIDTH  register reserved by an issuing instruction.
- resv_en  in  1  reservation strobe.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits (used to drain before fence/CSR).

Behaviour:
- Reset: while rst = 1, all registers = 0 and all busy bits = 0; outputs follow combinationally (rdata = 0, rs_busy = 0, any_busy = 0). Deassertion mid-stream leaves the file clean; the first edge after release performs normal updates.
- Register 0: reads always return 0. Writes to 0 are ignored. Reservations of 0 are ignored. rs_busy is never set for 0.
- Reads are combinational, zero latency.
- Read with BYPASS = 1: if wl_we and wl_rd == rs[i] != 0, return wl_wd; else if wa_we and wa_rd == rs[i] != 0, return wa_wd; else return the stored value.
- Read with BYPASS = 0: always return the stored value.
- Writes on posedge clk.
  - Both ports enabled with different addresses: both are written.
  - Same address: load port (wl) wins.
- Busy bit b[r] on posedge clk, priority highest first:
  - flush: all b = 0. flush also overrides a same-cycle resv_en.
  - resv_en with resv_rd == r != 0: b[r] = 1. This overrides a same-cycle write release of r, because the new producer is in flight.
  - wa_we or wl_we to r: b[r] = 0.
  - Otherwise: hold.
- rs_busy[i]:
  - BYPASS = 1: b[rs[i]] AND no same-cycle write to rs[i]. A forwarded value is not treated as a hazard.
  - BYPASS = 0: b[rs[i]].
  - Always 0 for register 0.
- any_busy = OR of the registered busy bits; no bypass masking.
- A write to a non-busy register is legal: data is written and the busy bit stays 0.
- Repeated reservation of an already-busy register keeps it busy. There is no counting; the first write releases it.

Decomposition:
- Package reg_file_pkg holds:
  - default ADDR_WIDTH / WIDTH localparams,
  - typedefs reg_addr_t, reg_data_t,
  - constant REG_ZERO = 0.
- Sub-module register_scoreboard:
  - owns the busy vector with its flush / reserve / release priority and the any_busy reduction,
  - takes the write-port enables and addresses plus the resv/flush inputs,
  - exposes the busy vector.
- Top level holds the data array, write-port arbitration, read/bypass muxes and rs_busy masking.

Test Plan:
- Reset then read: assert rst with rs = {1,2} -> rdata = {0,0}, rs_busy = 0, any_busy = 0. Then write wa x5 = 0xDEADBEEF, deassert rst, read x5 -> 0xDEADBEEF one cycle after the write edge.
- Register 0: write wa x0 = 0x1234 and resv x0 -> reading x0 returns 0, rs_busy = 0, any_busy = 0.
- Bypass and collision:
  - BYPASS = 1: wa x3 = 0x11 and wl x3 = 0x22 in the same cycle, reading x3 -> rdata = 0x22 combinationally; next cycle the stored value is 0x22.
  - BYPASS = 0: the same-cycle read returns the old value 0, then 0x22.
- Scoreboard lifecycle:
  - resv x7 -> rs_busy for x7 = 1, any_busy = 1.
  - wl x7 = 0x99 -> busy is masked in that cycle (BYPASS = 1), cleared after the edge, and x7 reads 0x99.
- Simultaneous events:
  - resv x4 and wa x4 in the same cycle -> x4 is written and x4 remains busy.
  - flush together with resv x6 -> all busy bits = 0, any_busy = 0.
- Async reset mid-operation: set x1, x2 busy and x1 = 0xAA, then pulse rst between clock edges -> busy bits and data clear immediately without a clock edge.
